// File: rtl/controlador_somador_serial.sv
// Serial adder controller: feeds an external 2-bit ripple slice one bit-pair per
// clock, LSB first, registering the slice carry between steps.
module controlador_somador_serial #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [1:0]   slice_a,
   output logic [1:0]   slice_b,
   output logic         slice_cin,
   input  logic [1:0]   slice_s,
   input  logic         slice_cout,
   output logic [N-1:0] soma,
   output logic         cout,
   output logic         busy,
   output logic         done
);

   localparam int STEPS = N / 2;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {OCIOSO, SOMANDO, PRONTO} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  count_q, count_d;
   logic [N-1:0]   areg_q, areg_d;
   logic [N-1:0]   breg_q, breg_d;
   logic           carry_q, carry_d;
   logic [N-1:0]   sacc_q, sacc_d;
   logic [N-1:0]   soma_q, soma_d;
   logic           cout_q, cout_d;
   logic [N-1:0]   step_sum;

   // New sum pair enters at the MSB; after N/2 steps the LSB pair has reached bit 0.
   generate
      if (N == 2) begin : g_two
         assign step_sum = slice_s;
      end else begin : g_wide
         assign step_sum = {slice_s, sacc_q[N-1:2]};
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      areg_d  = areg_q;
      breg_d  = breg_q;
      carry_d = carry_q;
      sacc_d  = sacc_q;
      soma_d  = soma_q;
      cout_d  = cout_q;
      case (state_q)
         OCIOSO, PRONTO: begin
            if (start) begin
               areg_d  = a;
               breg_d  = b;
               carry_d = cin;
               count_d = '0;
               state_d = SOMANDO;
            end else begin
               state_d = OCIOSO;
            end
         end
         SOMANDO: begin
            areg_d  = areg_q >> 2;
            breg_d  = breg_q >> 2;
            sacc_d  = step_sum;
            carry_d = slice_cout;
            count_d = count_q + CW'(1);
            if (count_q == CW'(STEPS - 1)) begin
               soma_d  = step_sum;
               cout_d  = slice_cout;
               state_d = PRONTO;
            end
         end
         default: state_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= OCIOSO;
         count_q <= '0;
         areg_q  <= '0;
         breg_q  <= '0;
         carry_q <= 1'b0;
         sacc_q  <= '0;
         soma_q  <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         areg_q  <= areg_d;
         breg_q  <= breg_d;
         carry_q <= carry_d;
         sacc_q  <= sacc_d;
         soma_q  <= soma_d;
         cout_q  <= cout_d;
      end
   end

   assign busy      = (state_q == SOMANDO);
   assign done      = (state_q == PRONTO);
   assign slice_a   = busy ? areg_q[1:0] : 2'b00;
   assign slice_b   = busy ? breg_q[1:0] : 2'b00;
   assign slice_cin = busy ? carry_q : 1'b0;
   assign soma      = soma_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_controlador_somador_serial.sv
// Directed bench: an 8-bit controller and a 2-bit controller, each wired to a
// behavioural 2-bit adder slice.
module tb_controlador_somador_serial;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       cin = 1'b0;
   logic [1:0] slice_a, slice_b, slice_s;
   logic       slice_cin, slice_cout;
   logic [7:0] soma;
   logic       cout, busy, done;

   logic       start2 = 1'b0;
   logic [1:0] a2 = '0, b2 = '0;
   logic       cin2 = 1'b0;
   logic [1:0] sl2_a, sl2_b, sl2_s;
   logic       sl2_cin, sl2_cout;
   logic [1:0] soma2;
   logic       cout2, busy2, done2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign {slice_cout, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {2'b00, slice_cin};
   assign {sl2_cout, sl2_s}     = {1'b0, sl2_a} + {1'b0, sl2_b} + {2'b00, sl2_cin};

   controlador_somador_serial #(.N(8)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
      .slice_s(slice_s), .slice_cout(slice_cout),
      .soma(soma), .cout(cout), .busy(busy), .done(done)
   );

   controlador_somador_serial #(.N(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
      .slice_a(sl2_a), .slice_b(sl2_b), .slice_cin(sl2_cin),
      .slice_s(sl2_s), .slice_cout(sl2_cout),
      .soma(soma2), .cout(cout2), .busy(busy2), .done(done2)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] soma;
      logic       cout;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Launch one operation and follow it to done; sample on negedges.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                         output int lat, output int nbusy,
                         output logic [7:0] sa_seq, output logic [7:0] sb_seq);
      bit found;
      @(negedge clk);
      a = ta; b = tb_v; cin = tc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0; nbusy = 0; sa_seq = '0; sb_seq = '0; found = 0;
      while (!found && lat < 20) begin
         lat++;
         if (busy) begin
            nbusy++;
            sa_seq = {slice_a, sa_seq[7:2]};
            sb_seq = {slice_b, sb_seq[7:2]};
         end
         if (done) found = 1;
         else @(negedge clk);
      end
      if (!found) chk("done_timeout", 32'(lat), 32'd5);
   endtask

   initial begin
      int lat, nbusy, ndone, t1, t2;
      logic [7:0] sa_seq, sb_seq;

      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
      vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
      vecs[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
      vecs[5] = '{8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0};
      vecs[6] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
      vecs[7] = '{8'hC3, 8'h81, 1'b1, 8'h45, 1'b1};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_soma", 32'(soma), 32'h0);
      chk("rst_cout", 32'(cout), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_slice_a", 32'(slice_a), 32'h0);

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat, nbusy, sa_seq, sb_seq);
         $display("op %0d: 0x%02h + 0x%02h + %0d -> soma=0x%02h cout=%0d lat=%0d",
                  i, vecs[i].a, vecs[i].b, vecs[i].cin, soma, cout, lat);
         chk("latency", 32'(lat), 32'd5);
         chk("busy_cycles", 32'(nbusy), 32'd4);
         chk("slice_a_seq", 32'(sa_seq), 32'(vecs[i].a));
         chk("slice_b_seq", 32'(sb_seq), 32'(vecs[i].b));
         chk("soma", 32'(soma), 32'(vecs[i].soma));
         chk("cout", 32'(cout), 32'(vecs[i].cout));
         chk("busy_at_done", 32'(busy), 32'h0);
         @(negedge clk);
         chk("done_one_cycle", 32'(done), 32'h0);
         chk("soma_hold", 32'(soma), 32'(vecs[i].soma));
         chk("cout_hold", 32'(cout), 32'(vecs[i].cout));
      end

      // Start and operand changes while busy must be ignored.
      @(negedge clk);
      a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      ndone = 0; t1 = 0;
      for (int c = 1; c <= 12; c++) begin
         if (done) begin ndone++; t1 = c; end
         start = (c == 2);
         @(negedge clk);
      end
      start = 1'b0;
      $display("ignored-start op: soma=0x%02h dones=%0d at %0d", soma, ndone, t1);
      chk("ign_done_count", 32'(ndone), 32'd1);
      chk("ign_done_time", 32'(t1), 32'd5);
      chk("ign_soma", 32'(soma), 32'h46);
      chk("ign_cout", 32'(cout), 32'h0);

      // Reset in the 2nd SOMANDO cycle discards the operation.
      a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      $display("mid-op reset: busy=%0d done=%0d soma=0x%02h cout=%0d", busy, done, soma, cout);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_done", 32'(done), 32'h0);
      chk("mid_rst_soma", 32'(soma), 32'h0);
      chk("mid_rst_cout", 32'(cout), 32'h0);
      ndone = 0;
      for (int c = 0; c < 6; c++) begin
         if (done || busy) ndone++;
         @(negedge clk);
      end
      chk("post_rst_idle", 32'(ndone), 32'd0);
      run_op(8'h01, 8'h01, 1'b0, lat, nbusy, sa_seq, sb_seq);
      $display("after reset: 0x01 + 0x01 -> soma=0x%02h cout=%0d lat=%0d", soma, cout, lat);
      chk("after_rst_lat", 32'(lat), 32'd5);
      chk("after_rst_soma", 32'(soma), 32'h02);

      // Back-to-back: start held high, second operands presented in PRONTO.
      @(negedge clk);
      a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
      ndone = 0; t1 = 0; t2 = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (c >= 1) start = 1'b0;
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               t1 = c;
               chk("b2b_soma1", 32'(soma), 32'h00);
               chk("b2b_cout1", 32'(cout), 32'h1);
               a = 8'h0F; b = 8'h01; start = 1'b1;
            end else begin
               t2 = c;
               chk("b2b_soma2", 32'(soma), 32'h10);
               chk("b2b_cout2", 32'(cout), 32'h0);
            end
         end else if (c >= 1 && ndone == 1 && t1 == c - 1) begin
            chk("b2b_no_gap", 32'(busy), 32'h1);
            start = 1'b0;
         end else if (ndone == 0) begin
            start = 1'b1;
         end
      end
      start = 1'b0;
      $display("back-to-back: dones=%0d at %0d and %0d", ndone, t1, t2);
      chk("b2b_done_count", 32'(ndone), 32'd2);
      chk("b2b_spacing", 32'(t2 - t1), 32'd5);

      // N=2 instance: one SOMANDO cycle.
      @(negedge clk);
      a2 = 2'd3; b2 = 2'd3; cin2 = 1'b1; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      lat = 0; ndone = 0;
      while (ndone == 0 && lat < 10) begin
         lat++;
         if (done2) ndone = 1;
         else @(negedge clk);
      end
      $display("N=2: 3 + 3 + 1 -> soma=%0d cout=%0d lat=%0d", soma2, cout2, lat);
      chk("n2_latency", 32'(lat), 32'd2);
      chk("n2_soma", 32'(soma2), 32'd3);
      chk("n2_cout", 32'(cout2), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
